// File: rtl/keccak200_seq_ctrl.sv
// keccak200_seq_ctrl
// Sequencing controller for a round-based, byte-serial Keccak-f[200] datapath.
// It walks the datapath through LOAD (absorb NUM_BYTES bytes), ROUND
// (NUM_ROUNDS rounds, one per cycle) and UNLOAD (squeeze NUM_BYTES bytes).
// Optional feature macro: KECCAK200_SEQ_CTRL_ABORT_EN adds a synchronous
// i_Abort input that returns the controller to LOAD from any state.
module keccak200_seq_ctrl #(
  parameter int NUM_ROUNDS = 18,
  parameter int NUM_BYTES  = 25
) (
  input  logic       Clock,
  input  logic       Reset,
`ifdef KECCAK200_SEQ_CTRL_ABORT_EN
  input  logic       i_Abort,
`endif
  input  logic       i_InValid,
  output logic       o_InReady,
  output logic       o_OutValid,
  input  logic       i_OutReady,
  output logic       o_OutLast,
  output logic       o_DpShiftEn,
  output logic       o_DpRoundEn,
  output logic [7:0] o_DpRoundConst,
  output logic       o_Busy
);

  // Counter widths follow the counter limits; a single-value counter still
  // needs one bit so the register exists.
  localparam int BW = (NUM_BYTES  > 1) ? $clog2(NUM_BYTES)  : 1;
  localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;

  localparam logic [BW-1:0] LAST_BYTE  = BW'(NUM_BYTES - 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ROUND  = 2'd1,
    ST_UNLOAD = 2'd2
  } state_t;

  state_t          r_State;
  state_t          w_NextState;
  logic [BW-1:0]   r_ByteCnt;
  logic [BW-1:0]   w_NextByteCnt;
  logic [RW-1:0]   r_RoundCnt;
  logic [RW-1:0]   w_NextRoundCnt;
  logic [4:0]      w_RoundIdx;
  logic            w_Abort;

`ifdef KECCAK200_SEQ_CTRL_ABORT_EN
  assign w_Abort = i_Abort;
`else
  assign w_Abort = 1'b0;
`endif

  // Round index widened to the table address width; entries past the
  // eighteenth are never reached because RoundCnt stops at NUM_ROUNDS-1.
  assign w_RoundIdx = 5'(r_RoundCnt);

  function automatic logic [7:0] rcLookup(input logic [4:0] idx);
    logic [7:0] rc;
    rc = 8'h00;
    case (idx)
      5'd0:  rc = 8'h01;
      5'd1:  rc = 8'h82;
      5'd2:  rc = 8'h8A;
      5'd3:  rc = 8'h00;
      5'd4:  rc = 8'h8B;
      5'd5:  rc = 8'h01;
      5'd6:  rc = 8'h81;
      5'd7:  rc = 8'h09;
      5'd8:  rc = 8'h8A;
      5'd9:  rc = 8'h88;
      5'd10: rc = 8'h09;
      5'd11: rc = 8'h0A;
      5'd12: rc = 8'h8B;
      5'd13: rc = 8'h8B;
      5'd14: rc = 8'h89;
      5'd15: rc = 8'h03;
      5'd16: rc = 8'h02;
      5'd17: rc = 8'h80;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // State and counter registers; reset drops straight back into an empty LOAD.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_State    <= ST_LOAD;
      r_ByteCnt  <= '0;
      r_RoundCnt <= '0;
    end else begin
      r_State    <= w_NextState;
      r_ByteCnt  <= w_NextByteCnt;
      r_RoundCnt <= w_NextRoundCnt;
    end
  end

  // Next-state, counter update and output decode; abort overrides everything.
  always_comb begin
    w_NextState    = r_State;
    w_NextByteCnt  = r_ByteCnt;
    w_NextRoundCnt = r_RoundCnt;
    o_InReady      = 1'b0;
    o_OutValid     = 1'b0;
    o_OutLast      = 1'b0;
    o_DpShiftEn    = 1'b0;
    o_DpRoundEn    = 1'b0;
    o_DpRoundConst = 8'h00;
    o_Busy         = 1'b0;

    case (r_State)
      ST_LOAD: begin
        o_InReady   = 1'b1;
        o_DpShiftEn = i_InValid;
        if (i_InValid) begin
          if (r_ByteCnt == LAST_BYTE) begin
            w_NextState    = ST_ROUND;
            w_NextByteCnt  = '0;
            w_NextRoundCnt = '0;
          end else begin
            w_NextByteCnt = r_ByteCnt + BW'(1);
          end
        end
      end

      ST_ROUND: begin
        o_DpRoundEn    = 1'b1;
        o_Busy         = 1'b1;
        o_DpRoundConst = rcLookup(w_RoundIdx);
        if (r_RoundCnt == LAST_ROUND) begin
          w_NextState    = ST_UNLOAD;
          w_NextRoundCnt = '0;
        end else begin
          w_NextRoundCnt = r_RoundCnt + RW'(1);
        end
      end

      ST_UNLOAD: begin
        o_OutValid  = 1'b1;
        o_DpShiftEn = i_OutReady;
        o_OutLast   = (r_ByteCnt == LAST_BYTE);
        if (i_OutReady) begin
          if (r_ByteCnt == LAST_BYTE) begin
            w_NextState   = ST_LOAD;
            w_NextByteCnt = '0;
          end else begin
            w_NextByteCnt = r_ByteCnt + BW'(1);
          end
        end
      end

      default: begin
        w_NextState    = ST_LOAD;
        w_NextByteCnt  = '0;
        w_NextRoundCnt = '0;
      end
    endcase

    if (w_Abort) begin
      w_NextState    = ST_LOAD;
      w_NextByteCnt  = '0;
      w_NextRoundCnt = '0;
      o_InReady      = 1'b0;
      o_DpShiftEn    = 1'b0;
      o_DpRoundEn    = 1'b0;
    end
  end

endmodule

// File: tb/tb_keccak200_seq_ctrl.sv
// tb_keccak200_seq_ctrl
// Directed bench for keccak200_seq_ctrl. A byte shift register stands in for
// the datapath (rounds leave it unchanged), so squeezed bytes must come back
// in load order. Honours KECCAK200_SEQ_CTRL_ABORT_EN when defined.
module tb_keccak200_seq_ctrl;

  localparam int NR = 18;
  localparam int NB = 25;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       inValid, outReady, abort;
  logic [7:0] inData;
  logic       inReady, outValid, outLast, shiftEn, roundEn, busy;
  logic [7:0] roundConst;

  logic       inValid2, outReady2;
  logic       inReady2, outValid2, outLast2, shiftEn2, roundEn2, busy2;
  logic [7:0] roundConst2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rcRef   [NR];
  logic [7:0] loadRef [NB];
  logic [7:0] dpModel [NB];

  typedef struct {
    logic       iv;
    logic       ordy;
    logic [7:0] data;
    logic       expInReady;
    logic       expOutValid;
    logic       expOutLast;
    logic       expShift;
    logic       expRound;
    logic [7:0] expRc;
    logic       expBusy;
    logic       chkByte;
    logic [7:0] expByte;
  } vec_t;

  vec_t vecs[$];

  always #5 Clock = ~Clock;

  keccak200_seq_ctrl #(.NUM_ROUNDS(NR), .NUM_BYTES(NB)) u_dut (
    .Clock          (Clock),
    .Reset          (Reset),
`ifdef KECCAK200_SEQ_CTRL_ABORT_EN
    .i_Abort        (abort),
`endif
    .i_InValid      (inValid),
    .o_InReady      (inReady),
    .o_OutValid     (outValid),
    .i_OutReady     (outReady),
    .o_OutLast      (outLast),
    .o_DpShiftEn    (shiftEn),
    .o_DpRoundEn    (roundEn),
    .o_DpRoundConst (roundConst),
    .o_Busy         (busy)
  );

  keccak200_seq_ctrl #(.NUM_ROUNDS(1), .NUM_BYTES(2)) u_small (
    .Clock          (Clock),
    .Reset          (Reset),
`ifdef KECCAK200_SEQ_CTRL_ABORT_EN
    .i_Abort        (1'b0),
`endif
    .i_InValid      (inValid2),
    .o_InReady      (inReady2),
    .o_OutValid     (outValid2),
    .i_OutReady     (outReady2),
    .o_OutLast      (outLast2),
    .o_DpShiftEn    (shiftEn2),
    .o_DpRoundEn    (roundEn2),
    .o_DpRoundConst (roundConst2),
    .o_Busy         (busy2)
  );

  // Stand-in datapath: shift in at the top, byte 0 leaves first.
  always @(posedge Clock) begin
    if (shiftEn) begin
      for (int i = 0; i < NB - 1; i++) dpModel[i] <= dpModel[i+1];
      dpModel[NB-1] <= inData;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic ordy, input logic [7:0] data);
    inValid  = iv;
    outReady = ordy;
    inData   = data;
  endtask

  task automatic nextCycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("vec%0d.inReady", idx),  inReady,    v.expInReady);
    checkOutput($sformatf("vec%0d.outValid", idx), outValid,   v.expOutValid);
    checkOutput($sformatf("vec%0d.outLast", idx),  outLast,    v.expOutLast);
    checkOutput($sformatf("vec%0d.shiftEn", idx),  shiftEn,    v.expShift);
    checkOutput($sformatf("vec%0d.roundEn", idx),  roundEn,    v.expRound);
    checkOutput($sformatf("vec%0d.rc", idx),       roundConst, v.expRc);
    checkOutput($sformatf("vec%0d.busy", idx),     busy,       v.expBusy);
    if (v.chkByte) checkOutput($sformatf("vec%0d.byte", idx), dpModel[0], v.expByte);
  endtask

  // Starts and ends at posedge+1 with the DUT idle in LOAD.
  task automatic runTable(input string tag);
    $display("[TB] table run: %s", tag);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].iv, vecs[i].ordy, vecs[i].data);
      #1;
      checkVector(i, vecs[i]);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic loadPlain();
    for (int i = 0; i < NB; i++) begin
      applyStimulus(1'b1, 1'b0, loadRef[i]);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  task automatic waitForOutValid(input string tag);
    int n;
    n = 0;
    while (!outValid && n < 100) begin
      nextCycle();
      n++;
    end
    checkOutput({tag, ".outValidSeen"}, outValid, 1'b1);
  endtask

  initial begin
    vec_t v;
    int accepted, pulses, cycles, rounds, outIdx, stall;

    rcRef = '{8'h01, 8'h82, 8'h8A, 8'h00, 8'h8B, 8'h01, 8'h81, 8'h09, 8'h8A,
              8'h88, 8'h09, 8'h0A, 8'h8B, 8'h8B, 8'h89, 8'h03, 8'h02, 8'h80};
    loadRef[0] = 8'h01; loadRef[1] = 8'hEF; loadRef[2] = 8'hCD;
    loadRef[3] = 8'hAB; loadRef[4] = 8'h89; loadRef[5] = 8'h67;
    loadRef[6] = 8'h45; loadRef[7] = 8'h23; loadRef[8] = 8'h01;
    for (int i = 9; i < NB; i++) loadRef[i] = 8'hFF;

    // Full pass with no stalls: load, rounds (InValid held high to be ignored),
    // unload, then back to an idle LOAD.
    for (int i = 0; i < NB; i++) begin
      v = '{1'b1, 1'b0, loadRef[i], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
      vecs.push_back(v);
    end
    for (int r = 0; r < NR; r++) begin
      v = '{1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rcRef[r], 1'b1, 1'b0, 8'h00};
      vecs.push_back(v);
    end
    for (int i = 0; i < NB; i++) begin
      v = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, (i == NB - 1), 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, loadRef[i]};
      vecs.push_back(v);
    end
    v = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs.push_back(v);

    Reset = 1'b1;
    abort = 1'b0;
    inValid2 = 1'b0;
    outReady2 = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge Clock);
    #1;
    checkOutput("reset.inReady",  inReady,    1'b1);
    checkOutput("reset.outValid", outValid,   1'b0);
    checkOutput("reset.outLast",  outLast,    1'b0);
    checkOutput("reset.shiftEn",  shiftEn,    1'b0);
    checkOutput("reset.roundEn",  roundEn,    1'b0);
    checkOutput("reset.rc",       roundConst, 8'h00);
    checkOutput("reset.busy",     busy,       1'b0);
    Reset = 1'b0;

    runTable("back-to-back");

    // Input stalls: InValid toggles every cycle during LOAD.
    accepted = 0; pulses = 0; cycles = 0;
    while (accepted < NB && cycles < 200) begin
      applyStimulus((cycles % 2) == 0, 1'b0, (accepted < NB) ? loadRef[accepted] : 8'h00);
      #1;
      pulses += int'(shiftEn);
      if (inValid && inReady) accepted++;
      nextCycle();
      cycles++;
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("stall.accepted", accepted, NB);
    checkOutput("stall.pulses",   pulses,   NB);
    #1;
    checkOutput("stall.roundStartBusy", busy,    1'b1);
    checkOutput("stall.roundStartEn",   roundEn, 1'b1);
    checkOutput("stall.roundStartRc",   roundConst, 8'h01);
    rounds = 0;
    while (roundEn && rounds < 100) begin
      rounds++;
      nextCycle();
    end
    checkOutput("stall.roundCycles", rounds, NR);

    // Output backpressure: OutReady low for 5 cycles at byte 10.
    outIdx = 0; stall = 0; cycles = 0;
    while (outIdx < NB && cycles < 200) begin
      if (outIdx == 10 && stall < 5) begin
        applyStimulus(1'b0, 1'b0, 8'h00);
        #1;
        checkOutput("bp.stallValid", outValid, 1'b1);
        checkOutput("bp.stallShift", shiftEn, 1'b0);
        checkOutput("bp.stallByte",  dpModel[0], loadRef[10]);
        stall++;
      end else begin
        applyStimulus(1'b0, 1'b1, 8'h00);
        #1;
        checkOutput($sformatf("bp.valid%0d", outIdx), outValid, 1'b1);
        checkOutput($sformatf("bp.byte%0d", outIdx),  dpModel[0], loadRef[outIdx]);
        checkOutput($sformatf("bp.last%0d", outIdx),  outLast, (outIdx == NB - 1));
        outIdx++;
      end
      nextCycle();
      cycles++;
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("bp.bytesOut", outIdx, NB);
    #1;
    checkOutput("bp.backInReady",  inReady,  1'b1);
    checkOutput("bp.backOutValid", outValid, 1'b0);

    // Reset asserted mid-ROUND; outputs must drop before the next edge.
    loadPlain();
    repeat (7) nextCycle();
    checkOutput("rst.inRound", busy, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("rst.inReady",  inReady,    1'b1);
    checkOutput("rst.outValid", outValid,   1'b0);
    checkOutput("rst.roundEn",  roundEn,    1'b0);
    checkOutput("rst.rc",       roundConst, 8'h00);
    checkOutput("rst.busy",     busy,       1'b0);
    checkOutput("rst.shiftEn",  shiftEn,    1'b0);
    nextCycle();
    Reset = 1'b0;
    runTable("after-reset");

`ifdef KECCAK200_SEQ_CTRL_ABORT_EN
    // Abort during UNLOAD byte 3, then a clean full pass.
    loadPlain();
    waitForOutValid("abort");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      nextCycle();
    end
    abort = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h00);
    #1;
    checkOutput("abort.shiftEn", shiftEn, 1'b0);
    checkOutput("abort.roundEn", roundEn, 1'b0);
    nextCycle();
    abort = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    #1;
    checkOutput("abort.inReady",  inReady,  1'b1);
    checkOutput("abort.outValid", outValid, 1'b0);
    checkOutput("abort.busy",     busy,     1'b0);
    runTable("after-abort");
`endif

    // Minimal configuration: two bytes, one round.
    inValid2 = 1'b1;
    #1;
    checkOutput("small.inReady0", inReady2, 1'b1);
    checkOutput("small.shift0",   shiftEn2, 1'b1);
    nextCycle();
    checkOutput("small.shift1",   shiftEn2, 1'b1);
    nextCycle();
    inValid2 = 1'b0;
    #1;
    checkOutput("small.roundEn", roundEn2,    1'b1);
    checkOutput("small.rc",      roundConst2, 8'h01);
    checkOutput("small.busy",    busy2,       1'b1);
    checkOutput("small.inReadyR", inReady2,   1'b0);
    nextCycle();
    outReady2 = 1'b1;
    #1;
    checkOutput("small.outValid0", outValid2, 1'b1);
    checkOutput("small.outLast0",  outLast2,  1'b0);
    checkOutput("small.shiftOut0", shiftEn2,  1'b1);
    nextCycle();
    checkOutput("small.outValid1", outValid2, 1'b1);
    checkOutput("small.outLast1",  outLast2,  1'b1);
    nextCycle();
    outReady2 = 1'b0;
    #1;
    checkOutput("small.backLoad",  inReady2,  1'b1);
    checkOutput("small.outValidE", outValid2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
